// File: rtl/prog_loader_if.sv
// Byte-stream input and memory-preload output bundle shared by prog_loader and its neighbours.
// The stream source drives the master side and the loader sits on the slave side.
interface prog_loader_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  preload_en_instr;
    logic                  preload_en_data;
    logic [ADDR_WIDTH-1:0] preload_addr;
    logic [DATA_WIDTH-1:0] preload_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, preload_en_instr, preload_en_data, preload_addr, preload_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, preload_en_instr, preload_en_data, preload_addr, preload_data
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: parses framed byte sections into instruction/data memory
// preload writes and holds the core in reset until a RUN command arrives.
module prog_loader #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        areset_n,
    prog_loader_if.slave bus,
    output logic        core_rst_n,
    output logic        busy,
    output logic        error
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_WRITE,
        S_RUN
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t                state;
    logic                  target_instr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            cnt_lo;
    logic [15:0]           remaining;
    logic [1:0]            idx;
    // Only the first three bytes of a word need storing; the fourth goes straight to preload_data.
    logic [DATA_WIDTH-9:0] word;
    logic                  take;
    logic [15:0]           count_n;

    assign take    = bus.in_valid & bus.in_ready;
    assign count_n = {bus.in_data, cnt_lo};

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state                <= S_IDLE;
            target_instr         <= 1'b0;
            addr                 <= '0;
            cnt_lo               <= '0;
            remaining            <= '0;
            idx                  <= '0;
            word                 <= '0;
            bus.in_ready         <= 1'b1;
            bus.preload_en_instr <= 1'b0;
            bus.preload_en_data  <= 1'b0;
            bus.preload_addr     <= '0;
            bus.preload_data     <= '0;
            core_rst_n           <= 1'b0;
            busy                 <= 1'b0;
            error                <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        case (bus.in_data)
                            8'hA5, 8'h5A: begin
                                target_instr <= (bus.in_data == 8'hA5);
                                addr         <= '0;
                                state        <= S_CNT_LO;
                                busy         <= 1'b1;
                            end
                            8'hF0: begin
                                state      <= S_RUN;
                                core_rst_n <= 1'b1;
                            end
                            default: error <= 1'b1;
                        endcase
                    end
                end
                S_CNT_LO: begin
                    if (take) begin
                        cnt_lo <= bus.in_data;
                        state  <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (take) begin
                        if (count_n == '0) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else if ({1'b0, count_n} > MAX_N) begin
                            error <= 1'b1;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            remaining <= count_n;
                            idx       <= '0;
                            state     <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        idx  <= idx + 2'd1;
                        word <= {bus.in_data, word[DATA_WIDTH-9:8]};
                        if (idx == 2'd3) begin
                            state                <= S_WRITE;
                            bus.in_ready         <= 1'b0;
                            bus.preload_en_instr <= target_instr;
                            bus.preload_en_data  <= ~target_instr;
                            bus.preload_addr     <= addr;
                            bus.preload_data     <= {bus.in_data, word};
                        end
                    end
                end
                S_WRITE: begin
                    bus.preload_en_instr <= 1'b0;
                    bus.preload_en_data  <= 1'b0;
                    bus.in_ready         <= 1'b1;
                    addr                 <= addr + ADDR_WIDTH'(4);
                    remaining            <= remaining - 16'd1;
                    idx                  <= '0;
                    if (remaining == 16'd1) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_RUN: begin
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed vector table, hand-written corner sequences and
// randomized frame streams checked against a frame-level parser model.
module tb_prog_loader;
    localparam int unsigned MAXW = 1024;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  b [16];
        int unsigned len;
        int unsigned exp_writes;
        logic        exp_instr;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_run;
    } vec_t;

    logic clk = 1'b0;
    logic areset_n = 1'b1;
    logic core_rst_n, busy, error;

    int unsigned checks = 0;
    int unsigned failures = 0;

    wr_t obs_q [$];
    wr_t exp_q [$];
    logic m_err, m_run;

    prog_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    prog_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe cycle is one write; strobes must be exclusive and stall input.
    always @(negedge clk) begin
        if (areset_n && (bus.preload_en_instr || bus.preload_en_data)) begin
            check("strobe_exclusive", 64'(bus.preload_en_instr & bus.preload_en_data), 64'd0);
            check("ready_low_on_write", 64'(bus.in_ready), 64'd0);
            obs_q.push_back('{instr: bus.preload_en_instr, addr: bus.preload_addr,
                              data: bus.preload_data});
        end
    end

    // Frame-level reference: walks the byte list section by section.
    function automatic void run_model(input logic [7:0] bs [$]);
        int unsigned i;
        int unsigned n;
        logic [7:0]  h;
        i = 0;
        exp_q.delete();
        m_err = 1'b0;
        m_run = 1'b0;
        while (i < bs.size() && !m_run) begin
            h = bs[i];
            i++;
            if (h == 8'hF0) begin
                m_run = 1'b1;
            end else if (h == 8'hA5 || h == 8'h5A) begin
                if (i + 2 > bs.size()) break;
                n = bs[i] + 256 * bs[i+1];
                i += 2;
                if (n > MAXW) begin
                    m_err = 1'b1;
                end else begin
                    for (int unsigned w = 0; w < n; w++) begin
                        if (i + 4 > bs.size()) begin
                            i = bs.size();
                            break;
                        end
                        exp_q.push_back('{instr: (h == 8'hA5), addr: 32'(4 * w),
                                          data: {bs[i+3], bs[i+2], bs[i+1], bs[i]}});
                        i += 4;
                    end
                end
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    // Called and returns on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned guard;
        repeat ($urandom_range(0, gap)) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] bs [$], input int unsigned gap);
        foreach (bs[k]) send_byte(bs[k], gap);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset_n     = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        obs_q.delete();
        areset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_addr_data"}, {obs_q[i].addr, obs_q[i].data}, {exp_q[i].addr, exp_q[i].data});
            check({tag, "_target"}, 64'(obs_q[i].instr), 64'(exp_q[i].instr));
        end
        check({tag, "_error"}, 64'(error), 64'(m_err));
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(m_run));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    vec_t tv [6];

    initial begin
        logic [7:0] s [$];
        wr_t last;

        tv[0] = '{b: '{8'hA5,8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,0,0,0,0,0,0,0,0,0}, len: 7,
                  exp_writes: 1, exp_instr: 1, exp_addr: 32'h0, exp_data: 32'hDEADBEEF,
                  exp_err: 0, exp_run: 0};
        tv[1] = '{b: '{8'hA5,8'h00,8'h00,8'hF0,0,0,0,0,0,0,0,0,0,0,0,0}, len: 4,
                  exp_writes: 0, exp_instr: 0, exp_addr: 0, exp_data: 0, exp_err: 0, exp_run: 1};
        tv[2] = '{b: '{8'h33,8'hA5,8'h01,8'h00,8'h11,8'h22,8'h33,8'h44,0,0,0,0,0,0,0,0}, len: 8,
                  exp_writes: 1, exp_instr: 1, exp_addr: 32'h0, exp_data: 32'h44332211,
                  exp_err: 1, exp_run: 0};
        tv[3] = '{b: '{8'h5A,8'h01,8'h04,8'hA5,8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,0,0,0,0,0,0},
                  len: 10, exp_writes: 1, exp_instr: 1, exp_addr: 32'h0, exp_data: 32'h04030201,
                  exp_err: 1, exp_run: 0};
        tv[4] = '{b: '{8'h5A,8'h01,8'h00,8'h78,8'h56,8'h34,8'h12,0,0,0,0,0,0,0,0,0}, len: 7,
                  exp_writes: 1, exp_instr: 0, exp_addr: 32'h0, exp_data: 32'h12345678,
                  exp_err: 0, exp_run: 0};
        tv[5] = '{b: '{8'hA5,8'h02,8'h00,8'h10,8'h20,8'h30,8'h40,8'h50,8'h60,8'h70,8'h80,0,0,0,0,0},
                  len: 11, exp_writes: 2, exp_instr: 1, exp_addr: 32'h4, exp_data: 32'h80706050,
                  exp_err: 0, exp_run: 0};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(negedge clk);
        areset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", 64'({bus.in_ready, bus.preload_en_instr, bus.preload_en_data,
                                 core_rst_n, busy, error}), 64'b100000);
        check("reset_addr_data", {bus.preload_addr, bus.preload_data}, 64'd0);
        areset_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int v = 0; v < 6; v++) begin
            do_reset();
            s.delete();
            for (int unsigned k = 0; k < tv[v].len; k++) s.push_back(tv[v].b[k]);
            send_stream(s, 1);
            check($sformatf("vec%0d_writes", v), 64'(obs_q.size()), 64'(tv[v].exp_writes));
            if (tv[v].exp_writes > 0 && obs_q.size() > 0) begin
                last = obs_q[obs_q.size()-1];
                check($sformatf("vec%0d_last_write", v), {last.addr, last.data},
                      {tv[v].exp_addr, tv[v].exp_data});
                check($sformatf("vec%0d_target", v), 64'(last.instr), 64'(tv[v].exp_instr));
            end
            check($sformatf("vec%0d_error", v), 64'(error), 64'(tv[v].exp_err));
            check($sformatf("vec%0d_core_rst_n", v), 64'(core_rst_n), 64'(tv[v].exp_run));
            check($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
        end

        // Three-word data section, back-to-back bytes
        do_reset();
        s.delete();
        s.push_back(8'h5A); s.push_back(8'h03); s.push_back(8'h00);
        for (int k = 0; k < 12; k++) s.push_back(8'(k + 1));
        send_stream(s, 0);
        check("three_words_count", 64'(obs_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            check("three_words_addr", 64'(obs_q[i].addr), 64'(4 * i));
            check("three_words_target", 64'(obs_q[i].instr), 64'd0);
        end

        // RUN timing: core_rst_n rises the cycle after F0 is accepted, later bytes are discarded
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hF0;
        check("run_before_accept", 64'(core_rst_n), 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("run_after_accept", 64'(core_rst_n), 64'd1);
        s.delete();
        s.push_back(8'hA5); s.push_back(8'h01); s.push_back(8'h00);
        s.push_back(8'h01); s.push_back(8'h02); s.push_back(8'h03); s.push_back(8'h04);
        send_stream(s, 0);
        check("run_discard_writes", 64'(obs_q.size()), 64'd0);
        check("run_hold", 64'({core_rst_n, bus.in_ready, busy}), 64'b110);

        // Gaps inside a word, then reset mid-frame
        do_reset();
        s.delete();
        s.push_back(8'hA5); s.push_back(8'h02); s.push_back(8'h00);
        s.push_back(8'hAA); s.push_back(8'hBB);
        foreach (s[k]) send_byte(s[k], 3);
        repeat (10) @(negedge clk);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_no_write", 64'(obs_q.size()), 64'd0);
        areset_n = 1'b0;
        #1;
        check("midreset_state", 64'({core_rst_n, busy, bus.in_ready}), 64'b001);
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        check("midreset_no_write", 64'(obs_q.size()), 64'd0);
        s.delete();
        s.push_back(8'hA5); s.push_back(8'h01); s.push_back(8'h00);
        s.push_back(8'hCC); s.push_back(8'hDD); s.push_back(8'hEE); s.push_back(8'hFF);
        send_stream(s, 2);
        check("midreset_next_count", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() > 0)
            check("midreset_next_write", {obs_q[0].addr, obs_q[0].data}, {32'h0, 32'hFFEEDDCC});

        // Largest legal section: MAX_WORDS words
        do_reset();
        s.delete();
        s.push_back(8'h5A); s.push_back(8'(MAXW & 255)); s.push_back(8'(MAXW >> 8));
        for (int unsigned k = 0; k < 4 * MAXW; k++) s.push_back(8'($urandom));
        run_model(s);
        send_stream(s, 0);
        compare_model("max_words");

        // Randomized multi-frame streams
        for (int it = 0; it < 40; it++) begin
            int unsigned nfr;
            int unsigned n;
            int unsigned r;
            do_reset();
            s.delete();
            nfr = $urandom_range(1, 3);
            for (int unsigned f = 0; f < nfr; f++) begin
                r = $urandom_range(0, 19);
                if (r == 0) begin
                    s.push_back(8'hF0);
                    repeat ($urandom_range(0, 5)) s.push_back(8'($urandom));
                    break;
                end else if (r < 3) begin
                    s.push_back(8'($urandom_range(0, 8'h9F)));
                end else if (r < 5) begin
                    n = $urandom_range(MAXW + 1, 65535);
                    s.push_back(r[0] ? 8'hA5 : 8'h5A);
                    s.push_back(8'(n & 255));
                    s.push_back(8'(n >> 8));
                end else begin
                    n = $urandom_range(0, 5);
                    s.push_back(r[0] ? 8'hA5 : 8'h5A);
                    s.push_back(8'(n));
                    s.push_back(8'h00);
                    repeat (4 * n) s.push_back(8'($urandom));
                end
            end
            run_model(s);
            send_stream(s, 2);
            compare_model($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
